cn_page_reader: RTL and testbench

CN_PAGE_READER -- requirements
Module: cn_page_reader

---
 rtl/cn_page_reader_if.sv | 40 ++++
 rtl/cn_page_reader.sv | 180 ++++++++++++++++++
 tb/tb_cn_page_reader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cn_page_reader_if.sv
// rtl/cn_page_reader_if.sv - Bundle of the CN page reader's writer, RAM and evaluator-side signals
// Purpose: groups every non-clock/reset port of cn_page_reader.
// Ports (master = reader side):
//   wr_iter_finish  writer bank-full pulse                 (in to master)
//   ram_dout        LUT RAM read data, 1 cycle after rd_en (in to master)
//   page_ready      evaluator ready                        (in to master)
//   rd_en, rd_page_addr, rd_bank     RAM read request      (out of master)
//   page_data, page_valid, page_last page stream           (out of master)
//   bank_release, iter_cnt, decode_done, ovf_err status    (out of master)
interface cn_page_reader_if #(
    parameter int ROM_RD_BW    = 6,
    parameter int PAGE_ADDR_BW = 5,
    parameter int ITER_ADDR_BW = 6
);
    logic                    wr_iter_finish;
    logic [ROM_RD_BW-1:0]    ram_dout;
    logic                    rd_en;
    logic [PAGE_ADDR_BW-1:0] rd_page_addr;
    logic                    rd_bank;
    logic [ROM_RD_BW-1:0]    page_data;
    logic                    page_valid;
    logic                    page_ready;
    logic                    page_last;
    logic                    bank_release;
    logic [ITER_ADDR_BW-1:0] iter_cnt;
    logic                    decode_done;
    logic                    ovf_err;

    modport master (
        input  wr_iter_finish, ram_dout, page_ready,
        output rd_en, rd_page_addr, rd_bank, page_data, page_valid, page_last,
               bank_release, iter_cnt, decode_done, ovf_err
    );

    modport slave (
        output wr_iter_finish, ram_dout, page_ready,
        input  rd_en, rd_page_addr, rd_bank, page_data, page_valid, page_last,
               bank_release, iter_cnt, decode_done, ovf_err
    );
endinterface

// File: rtl/cn_page_reader.sv
// rtl/cn_page_reader.sv - Ping-pong CN LUT bank reader feeding pages to the CN evaluator
// Purpose: waits for the writer to fill a bank, reads its CN_LOAD_CYCLE pages
//   through a 2-entry output FIFO with valid/ready flow control, releases the
//   bank after the last page, and stops after MAX_ITER banks.
// Ports:
//   read_clk  clock, all state on rising edge
//   rst       asynchronous active-high reset
//   bus       cn_page_reader_if.master (writer pulse, RAM read port, page
//             stream, bank_release, iter_cnt, decode_done, ovf_err)
// Optional feature: define CN_READ_OVF_CHECK_EN to build the bank overflow
//   detector; without it ovf_err is tied to 0.
module cn_page_reader #(
    parameter int ROM_RD_BW     = 6,
    parameter int PAGE_ADDR_BW  = 5,
    parameter int CN_LOAD_CYCLE = 32,
    parameter int ITER_ADDR_BW  = 6,
    parameter int MAX_ITER      = 50
) (
    input logic              read_clk,
    input logic              rst,
    cn_page_reader_if.master bus
);
    localparam logic [PAGE_ADDR_BW-1:0] LAST_PAGE  = PAGE_ADDR_BW'(CN_LOAD_CYCLE - 1);
    localparam logic [ITER_ADDR_BW-1:0] MAX_ITER_V = ITER_ADDR_BW'(MAX_ITER);
    localparam logic [ITER_ADDR_BW-1:0] LAST_ITER  = ITER_ADDR_BW'(MAX_ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              bank_full_q, bank_full_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [PAGE_ADDR_BW-1:0] addr_q, addr_d;
    logic [ITER_ADDR_BW-1:0] iter_q, iter_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic [ROM_RD_BW-1:0]    fifo_data_q [2];
    logic [ROM_RD_BW-1:0]    fifo_data_d [2];
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    fifo_wr_q, fifo_wr_d;
    logic                    fifo_rd_q, fifo_rd_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;

    logic       fifo_valid;
    logic       fifo_pop;
    logic       last_xfer;
    logic [1:0] eff_occ;
    logic       room;
    logic       issue;
    logic [1:0] set_vec;
    logic [1:0] clr_vec;

    // Occupancy counts the entry leaving this cycle as already gone; without
    // that the 2-entry FIFO could only sustain one page every other cycle.
    assign fifo_valid = (fifo_cnt_q != 2'd0);
    assign fifo_pop   = fifo_valid & bus.page_ready;
    assign last_xfer  = fifo_pop & fifo_last_q[fifo_rd_q];
    assign eff_occ    = fifo_cnt_q - {1'b0, fifo_pop};
    assign room       = (({1'b0, eff_occ} + {2'b00, inflight_q}) < 3'd2);

    assign set_vec = bus.wr_iter_finish ? (wr_ptr_q ? 2'b10 : 2'b01) : 2'b00;
    assign clr_vec = last_xfer ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;

    // FSM: state register
    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bank_full_q[rd_bank_q]) state_d = S_READ;
            S_READ:  if (issue && (addr_q == LAST_PAGE)) state_d = S_DRAIN;
            S_DRAIN: if (last_xfer) state_d = (iter_q == LAST_ITER) ? S_DONE : S_IDLE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        issue = (state_q == S_READ) && room;
    end

    // Datapath next-state
    always_comb begin
        bank_full_d     = (bank_full_q & ~clr_vec) | set_vec;  // a set in the clear cycle wins
        wr_ptr_d        = wr_ptr_q ^ bus.wr_iter_finish;
        rd_bank_d       = rd_bank_q ^ last_xfer;
        iter_d          = (last_xfer && (iter_q != MAX_ITER_V)) ? iter_q + 1'b1 : iter_q;
        addr_d          = addr_q;
        inflight_d      = issue;
        inflight_last_d = issue && (addr_q == LAST_PAGE);
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        fifo_wr_d       = fifo_wr_q;
        fifo_rd_d       = fifo_rd_q;
        fifo_cnt_d      = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};

        if (issue) begin
            addr_d = (addr_q == LAST_PAGE) ? '0 : addr_q + 1'b1;
        end
        // RAM data for last cycle's read arrives now; room was reserved at issue.
        if (inflight_q) begin
            fifo_data_d[fifo_wr_q] = bus.ram_dout;
            fifo_last_d[fifo_wr_q] = inflight_last_q;
            fifo_wr_d              = ~fifo_wr_q;
        end
        if (fifo_pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end
    end

    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            bank_full_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_bank_q       <= 1'b0;
            addr_q          <= '0;
            iter_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            fifo_wr_q       <= 1'b0;
            fifo_rd_q       <= 1'b0;
            fifo_cnt_q      <= '0;
        end else begin
            bank_full_q     <= bank_full_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_bank_q       <= rd_bank_d;
            addr_q          <= addr_d;
            iter_q          <= iter_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            fifo_wr_q       <= fifo_wr_d;
            fifo_rd_q       <= fifo_rd_d;
            fifo_cnt_q      <= fifo_cnt_d;
        end
    end

`ifdef CN_READ_OVF_CHECK_EN
    logic ovf_q, ovf_d;

    // Overflow only when the target bank is full and not being freed this cycle.
    always_comb begin
        ovf_d = ovf_q | (bus.wr_iter_finish & bank_full_q[wr_ptr_q] & ~clr_vec[wr_ptr_q]);
    end

    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf_err = ovf_q;
`else
    assign bus.ovf_err = 1'b0;
`endif

    assign bus.rd_en        = issue;
    assign bus.rd_page_addr = addr_q;
    assign bus.rd_bank      = rd_bank_q;
    assign bus.page_valid   = fifo_valid;
    assign bus.page_data    = fifo_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign bus.page_last    = fifo_valid & fifo_last_q[fifo_rd_q];
    assign bus.bank_release = last_xfer;
    assign bus.iter_cnt     = iter_q;
    assign bus.decode_done  = (state_q == S_DONE);
endmodule

// File: tb/tb_cn_page_reader.sv
// tb/tb_cn_page_reader.sv - Self-checking bench for cn_page_reader against a bank/page reference model
module tb_cn_page_reader;
    localparam int MAXI = 3;
    localparam int NPG  = 32;

    logic read_clk;
    logic rst;

    cn_page_reader_if #(.ROM_RD_BW(6), .PAGE_ADDR_BW(5), .ITER_ADDR_BW(6)) bus_if ();

    cn_page_reader #(
        .ROM_RD_BW(6), .PAGE_ADDR_BW(5), .CN_LOAD_CYCLE(NPG),
        .ITER_ADDR_BW(6), .MAX_ITER(MAXI)
    ) dut (
        .read_clk(read_clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    int checks = 0;
    int errors = 0;

    logic [5:0] ram_mem [2][NPG];

    // reference model state
    int m_full [2];
    int m_wptr, m_rbank, m_xidx, m_iidx, m_iter, m_done, m_ovf;
    int m_issued, m_xferred, m_releases;
    int prev_stall;
    logic [5:0] prev_data;
    int pend_rd, pend_bank, pend_addr;
    int cyc, rd0_cyc, ready_mode;
    int valid_cycles, first_valid_cyc, last_valid_cyc, rd_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_wptr = 0; m_rbank = 0; m_xidx = 0; m_iidx = 0;
        m_iter = 0; m_done = 0; m_ovf = 0;
        m_issued = 0; m_xferred = 0; m_releases = 0;
        prev_stall = 0; prev_data = '0; pend_rd = 0;
        valid_cycles = 0; first_valid_cyc = -1; last_valid_cyc = -1; rd_count = 0;
    endtask

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic observe();
        logic xfer, last;
        int   clr_bank;
        cyc++;
        xfer = bus_if.page_valid && bus_if.page_ready;
        last = xfer && (m_xidx == NPG - 1);
        check("iter_cnt", 32'(bus_if.iter_cnt), 32'(m_iter));
        check("decode_done", 32'(bus_if.decode_done), 32'(m_done));
        check("ovf_err", 32'(bus_if.ovf_err), 32'(m_ovf));
        check("rd_bank", 32'(bus_if.rd_bank), 32'(m_rbank));
        check("bank_release", 32'(bus_if.bank_release), 32'(last));
        if (prev_stall != 0) begin
            check("stall_valid", 32'(bus_if.page_valid), 32'd1);
            check("stall_data", 32'(bus_if.page_data), 32'(prev_data));
        end
        if (bus_if.page_valid) begin
            check("valid_backed", 32'(m_issued > m_xferred), 32'd1);
            check("page_last", 32'(bus_if.page_last), 32'(m_xidx == NPG - 1));
            if (m_xidx == 0 && prev_stall == 0)
                check("first_valid_latency", 32'(cyc - rd0_cyc), 32'd2);
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
        end else begin
            check("page_last_idle", 32'(bus_if.page_last), 32'd0);
        end
        if (xfer)
            check("page_data", 32'(bus_if.page_data), 32'(ram_mem[m_rbank][m_xidx]));
        if (bus_if.rd_en) begin
            check("rd_allowed", 32'(m_full[m_rbank] != 0 && m_done == 0), 32'd1);
            check("rd_addr", 32'(bus_if.rd_page_addr), 32'(m_iidx));
            check("rd_room", 32'((m_issued - m_xferred - int'(xfer)) < 2), 32'd1);
            if (m_iidx == 0) rd0_cyc = cyc;
            m_issued++;
            rd_count++;
            m_iidx = (m_iidx + 1) % NPG;
        end
        pend_rd   = int'(bus_if.rd_en);
        pend_bank = int'(bus_if.rd_bank);
        pend_addr = int'(bus_if.rd_page_addr);
        clr_bank  = m_rbank;
        if (xfer) begin
            m_xferred++;
            m_xidx++;
            if (last) begin
                m_full[m_rbank] = 0;
                m_releases++;
                m_rbank ^= 1;
                m_xidx = 0;
                if (m_iter < MAXI) m_iter++;
                if (m_iter == MAXI) m_done = 1;
            end
        end
        if (bus_if.wr_iter_finish) begin
`ifdef CN_READ_OVF_CHECK_EN
            if (m_full[m_wptr] != 0 && !(last && clr_bank == m_wptr)) m_ovf = 1;
`endif
            m_full[m_wptr] = 1;
            m_wptr ^= 1;
        end
        prev_stall = int'(bus_if.page_valid && !bus_if.page_ready);
        prev_data  = bus_if.page_data;
    endtask

    task automatic cycle();
        @(negedge read_clk);
        observe();
        @(posedge read_clk);
        #1;
        bus_if.ram_dout = (pend_rd != 0) ? ram_mem[pend_bank][pend_addr] : 6'($urandom);
        bus_if.wr_iter_finish = 1'b0;
        case (ready_mode)
            0: bus_if.page_ready = 1'b1;
            1: bus_if.page_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: bus_if.page_ready = 1'($urandom);
            default: bus_if.page_ready = 1'b0;
        endcase
    endtask

    task automatic pulse();
        bus_if.wr_iter_finish = 1'b1;
        cycle();
    endtask

    task automatic run_until_release(input string tag, input int target, input int budget);
        int n = 0;
        while (m_releases < target && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(m_releases >= target), 32'd1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        check("rst_rd_en", 32'(bus_if.rd_en), 32'd0);
        check("rst_page_valid", 32'(bus_if.page_valid), 32'd0);
        check("rst_page_last", 32'(bus_if.page_last), 32'd0);
        check("rst_bank_release", 32'(bus_if.bank_release), 32'd0);
        check("rst_decode_done", 32'(bus_if.decode_done), 32'd0);
        check("rst_ovf_err", 32'(bus_if.ovf_err), 32'd0);
        check("rst_page_data", 32'(bus_if.page_data), 32'd0);
        check("rst_rd_page_addr", 32'(bus_if.rd_page_addr), 32'd0);
        check("rst_rd_bank", 32'(bus_if.rd_bank), 32'd0);
        check("rst_iter_cnt", 32'(bus_if.iter_cnt), 32'd0);
        repeat (2) @(posedge read_clk);
        #1;
        rst = 1'b0;
        bus_if.wr_iter_finish = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < NPG; p++)
                ram_mem[b][p] = 6'($urandom);
        cyc = 0; rd0_cyc = 0; ready_mode = 0;
        bus_if.wr_iter_finish = 1'b0;
        bus_if.ram_dout = '0;
        bus_if.page_ready = 1'b1;
        model_reset();
        reset_dut();

        // reset in the middle of bank 0
        pulse();
        n = 0;
        while (m_xferred < 10 && n < 100) begin cycle(); n++; end
        check("reached_page10", 32'(m_xferred >= 10), 32'd1);
        reset_dut();
        repeat (10) cycle();
        check("idle_after_reset_valid", 32'(valid_cycles), 32'd0);
        check("idle_after_reset_rd", 32'(rd_count), 32'd0);

        // single fill, ready held high
        pulse();
        run_until_release("fill_release", 1, 200);
        check("fill_valid_cycles", 32'(valid_cycles), 32'd32);
        check("fill_consecutive", 32'(last_valid_cyc - first_valid_cyc), 32'd31);
        check("fill_iter_cnt", 32'(bus_if.iter_cnt), 32'd1);

        // ping-pong: two pulses three cycles apart
        reset_dut();
        pulse();
        cycle();
        cycle();
        pulse();
        run_until_release("pingpong_release", 2, 400);
        repeat (3) cycle();
        check("pingpong_pages", 32'(m_xferred), 32'd64);
        check("pingpong_releases", 32'(m_releases), 32'd2);
        check("pingpong_rd_bank", 32'(bus_if.rd_bank), 32'd0);

        // backpressure 1,0,0,1 on the final bank, then termination
        ready_mode = 1;
        pulse();
        run_until_release("bp_release", 3, 600);
        cycle();
        check("bp_pages", 32'(m_xferred), 32'd96);
        check("done_flag", 32'(bus_if.decode_done), 32'd1);
        check("done_iter_cnt", 32'(bus_if.iter_cnt), 32'(MAXI));
        rd_count = 0;
        pulse();
        repeat (20) cycle();
        check("done_no_rd", 32'(rd_count), 32'd0);
        check("done_hold", 32'(bus_if.decode_done), 32'd1);

        // overflow: three fills with no release
        reset_dut();
        ready_mode = 3;
        for (int k = 0; k < 3; k++) begin
            pulse();
            repeat ($urandom_range(1, 4)) cycle();
        end
        cycle();
`ifdef CN_READ_OVF_CHECK_EN
        check("ovf_third_fill", 32'(bus_if.ovf_err), 32'd1);
`else
        check("ovf_disabled", 32'(bus_if.ovf_err), 32'd0);
`endif

        // fill landing on the bank being released in the same cycle
        reset_dut();
        ready_mode = 0;
        pulse();
        pulse();
        n = 0;
        while (m_xidx != NPG - 1 && n < 100) begin cycle(); n++; end
        check("reached_page31", 32'(m_xidx), 32'(NPG - 1));
        bus_if.wr_iter_finish = 1'b1;
        cycle();
        check("collide_release", 32'(m_releases), 32'd1);
        cycle();
        check("collide_no_ovf", 32'(bus_if.ovf_err), 32'd0);
        ready_mode = 2;
        run_until_release("collide_all_banks", 3, 1000);
        cycle();
        check("collide_done", 32'(bus_if.decode_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
